// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scan-code and key_event constants for the PS/2 front end.
// Byte classification helper used by the prefix FSM.
package ps2_pkg;

    localparam logic [7:0] SC_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] SC_PREFIX_BRK   = 8'hF0;
    localparam logic [7:0] SC_PREFIX_PAUSE = 8'hE1;
    localparam logic [7:0] SC_W            = 8'h1D;
    localparam logic [7:0] SC_A            = 8'h1C;
    localparam logic [7:0] SC_S            = 8'h1B;
    localparam logic [7:0] SC_D            = 8'h23;
    localparam logic [7:0] SC_G            = 8'h34;

    localparam int KE_VALID = 10;
    localparam int KE_EXT   = 9;
    localparam int KE_BRK   = 8;

    typedef enum logic [1:0] {
        BC_KEY,
        BC_EXT,
        BC_BRK,
        BC_PAUSE
    } byte_class_e;

    function automatic byte_class_e classify(input logic [7:0] b);
        byte_class_e c;
        unique case (1'b1)
            (b == SC_PREFIX_PAUSE): c = BC_PAUSE;
            (b == SC_PREFIX_EXT):   c = BC_EXT;
            (b == SC_PREFIX_BRK):   c = BC_BRK;
            default:                c = BC_KEY;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_frame_rx.sv
// ps2_frame_rx: pin sync, falling-edge detect and 11-bit frame deserialiser.
// Parity checked only when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_bad,
    output logic       rx_tout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_hist;
    logic          fall;
    logic          bit_in;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [TW-1:0] tcnt;
    logic          par_ok;

    assign fall    = clk_hist & ~clk_sync[1];
    assign bit_in  = data_sync[1];
    assign rx_byte = shreg;

    // two-flop synchronisers plus clock history; idle bus is high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_hist  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_hist  <= clk_sync[1];
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;

    // capture the parity bit of the current frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_bit <= 1'b0;
        end else if (fall && bit_cnt == 4'd9) begin
            par_bit <= bit_in;
        end
    end

    assign par_ok = ^{shreg, par_bit};
`else
    assign par_ok = 1'b1;
`endif

    // bit counter, shift register, idle timeout; an edge beats the timeout
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            tcnt     <= '0;
            rx_valid <= 1'b0;
            rx_bad   <= 1'b0;
            rx_tout  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_bad   <= 1'b0;
            rx_tout  <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                unique case (1'b1)
                    (bit_cnt == 4'd0): begin
                        if (!bit_in) bit_cnt <= 4'd1;
                    end
                    (bit_cnt >= 4'd1 && bit_cnt <= 4'd8): begin
                        shreg   <= {bit_in, shreg[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    (bit_cnt == 4'd9): begin
                        bit_cnt <= 4'd10;
                    end
                    default: begin
                        bit_cnt <= '0;
                        if (bit_in && par_ok) rx_valid <= 1'b1;
                        else                  rx_bad   <= 1'b1;
                    end
                endcase
            end else if (bit_cnt != 4'd0) begin
                if (tcnt == TMAX) begin
                    tcnt    <= '0;
                    bit_cnt <= '0;
                    rx_tout <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 receiver folding E0/F0/E1 prefixes into key_event.
// Optional parity check: define PS2_PARITY_CHECK_EN.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] key_event,
    output logic        frame_err
);

    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_bad;
    logic        rx_tout;
    logic        ext, ext_n;
    logic        brk, brk_n;
    logic [2:0]  skip, skip_n;
    logic [10:0] ev_n;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .rstn     (rstn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_bad   (rx_bad),
        .rx_tout  (rx_tout)
    );

    assign frame_err = rx_bad | rx_tout;

    // prefix state and one-cycle event register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            skip      <= '0;
            key_event <= '0;
        end else begin
            ext       <= ext_n;
            brk       <= brk_n;
            skip      <= skip_n;
            key_event <= ev_n;
        end
    end

    // a bad frame drops pending prefixes; a timeout keeps them
    always_comb begin
        ext_n  = ext;
        brk_n  = brk;
        skip_n = skip;
        ev_n   = '0;
        if (rx_bad) begin
            ext_n = 1'b0;
            brk_n = 1'b0;
        end else if (rx_valid) begin
            if (skip != 3'd0) begin
                skip_n = skip - 3'd1;
            end else begin
                unique case (classify(rx_byte))
                    BC_PAUSE: skip_n = 3'd7;
                    BC_EXT:   ext_n  = 1'b1;
                    BC_BRK:   brk_n  = 1'b1;
                    default: begin
                        ev_n[KE_VALID] = 1'b1;
                        ev_n[KE_EXT]   = ext;
                        ev_n[KE_BRK]   = brk;
                        ev_n[7:0]      = rx_byte;
                        ext_n          = 1'b0;
                        brk_n          = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed PS/2 frames against a queue-based event model.
// Timing is scaled down (short ps2_clk period, small timeout) to keep runs short.
module tb_ps2_key_decoder;

    localparam int TOUT = 300;
    localparam int HALF = 20;
    localparam int GAP  = 60;
    localparam int LAT  = 5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] key_event;
    logic        frame_err;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_event (key_event),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int ntot = 0;
    int npass = 0;
    int cyc = 0;
    int last_fall = 0;
    int err_seen = 0;
    int err_exp = 0;
    logic [10:0] exp_q[$];
    logic [10:0] last_ev = '0;
    bit m_ext = 0;
    bit m_brk = 0;
    int m_skip = 0;
    bit prev_err = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // behavioural model of the set-2 prefix rules
    task automatic model_byte(input logic [7:0] b);
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            exp_q.push_back({1'b1, m_ext, m_brk, b});
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(posedge clk); #1 ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop);
        logic p;
        bit accept;
        p = ~^b;
        if (bad_par) p = ~p;
        accept = !bad_stop;
`ifdef PS2_PARITY_CHECK_EN
        if (bad_par) accept = 0;
`endif
        if (accept) model_byte(b);
        else begin
            err_exp++;
            m_ext = 0;
            m_brk = 0;
        end
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(!bad_stop);
        repeat (GAP) @(posedge clk);
        check("drain", exp_q.size(), 0);
        check("err_count", err_seen, err_exp);
    endtask

    task automatic partial(input int n, input logic [7:0] b);
        ps2_bit(1'b0);
        for (int i = 0; i < n - 1; i++) ps2_bit(b[i]);
    endtask

    // every-cycle compare of DUT outputs against the model queue
    always @(negedge clk) begin
        if (!rstn) begin
            prev_err = 0;
        end else begin
            cyc++;
            if (frame_err) begin
                err_seen++;
                check("err_one_cycle", prev_err, 0);
            end
            prev_err = frame_err;
            if (key_event != '0) begin
                last_ev = key_event;
                if (exp_q.size() == 0) check("spurious_event", key_event, 0);
                else begin
                    check("event", key_event, exp_q.pop_front());
                    check("latency", cyc - last_fall, LAT);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("reset_key_event", key_event, 0);
        check("reset_frame_err", frame_err, 0);
        rstn = 1'b1;
        repeat (5) @(posedge clk);

        send_frame(8'h1D, 0, 0);
        check("make_lit", last_ev, 11'h41D);

        send_frame(8'hF0, 0, 0);
        check("brk_prefix_silent", last_ev, 11'h41D);
        send_frame(8'h1C, 0, 0);
        check("break_lit", last_ev, 11'h51C);

        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        check("ext_break_lit", last_ev, 11'h775);
        send_frame(8'h23, 0, 0);
        check("flags_cleared_lit", last_ev, 11'h423);

        send_frame(8'h34, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
        check("bad_parity_lit", last_ev, 11'h423);
`else
        check("bad_parity_lit", last_ev, 11'h434);
`endif

        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 1);
        send_frame(8'h1C, 0, 0);
        check("bad_stop_clears_lit", last_ev, 11'h41C);

        ps2_bit(1'b1);
        repeat (GAP) @(posedge clk);
        send_frame(8'h1D, 0, 0);
        check("bad_start_ignored_lit", last_ev, 11'h41D);

        partial(5, 8'h55);
        err_exp++;
        repeat (TOUT + 60) @(posedge clk);
        check("timeout_err", err_seen, err_exp);
        send_frame(8'h1B, 0, 0);
        check("after_timeout_lit", last_ev, 11'h41B);

        send_frame(8'hE1, 0, 0);
        send_frame(8'h14, 0, 0);
        send_frame(8'h77, 0, 0);
        send_frame(8'hE1, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h14, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h77, 0, 0);
        check("pause_silent", last_ev, 11'h41B);
        send_frame(8'h23, 0, 0);
        check("after_pause_lit", last_ev, 11'h423);

        send_frame(8'hE0, 0, 0);
        partial(6, 8'h1D);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("midreset_key_event", key_event, 0);
        check("midreset_frame_err", frame_err, 0);
        m_ext = 0;
        m_brk = 0;
        m_skip = 0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (GAP) @(posedge clk);
        send_frame(8'h1D, 0, 0);
        check("after_reset_lit", last_ev, 11'h41D);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
